// File: rtl/regfile_writeback_if.sv
// Bus bundle between the core datapath and the register-file write sequencer.
// The DUT uses the slave modport; the datapath (or a bench) uses master.
interface regfile_writeback_if #(
    parameter int unsigned REG_NUM_BITWIDTH = 5,
    parameter int unsigned WORD_BITWIDTH    = 32,
    parameter int unsigned LQ_DEPTH         = 2
);
    localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

    // ALU result port (cannot be stalled)
    logic                        alu_valid;
    logic [REG_NUM_BITWIDTH-1:0] alu_rd;
    logic [WORD_BITWIDTH-1:0]    alu_data;

    // Load result port (valid/ready handshake)
    logic                        ld_valid;
    logic                        ld_ready;
    logic [REG_NUM_BITWIDTH-1:0] ld_rd;
    logic [WORD_BITWIDTH-1:0]    ld_data;

    // Status
    logic                        stall;
    logic                        drop_err;
    logic [CNT_W-1:0]            lq_count;

    // Register file write port
    logic [REG_NUM_BITWIDTH-1:0] regToWrite;
    logic [WORD_BITWIDTH-1:0]    write_data;
    logic                        doRegWrite;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready, stall, drop_err, lq_count,
        input  regToWrite, write_data, doRegWrite
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready, stall, drop_err, lq_count,
        output regToWrite, write_data, doRegWrite
    );
endinterface

// File: rtl/regfile_writeback.sv
// Write-port sequencer for the 32-entry register file.
// Merges un-stallable ALU results with handshaked load results onto the single
// register-file write port, queueing loads that collide with an ALU write.
// Optional feature macro: REGFILE_WB_CLEAR_EN -- when defined, a post-reset
// sweep writes zero to x1..x31 before normal operation starts.
module regfile_writeback #(
    parameter int unsigned REG_NUM_BITWIDTH = 5,
    parameter int unsigned WORD_BITWIDTH    = 32,
    parameter int unsigned LQ_DEPTH         = 2
) (
    input  logic               clk,
    input  logic               rst,
    regfile_writeback_if.slave wb
);
    localparam int unsigned RW    = REG_NUM_BITWIDTH;
    localparam int unsigned DW    = WORD_BITWIDTH;
    localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

`ifdef REGFILE_WB_CLEAR_EN
    localparam state_e RST_STATE = ST_CLEAR;
`else
    localparam state_e RST_STATE = ST_RUN;
`endif

    // One load-queue slot; a killed slot still occupies space but never writes
    typedef struct packed {
        logic          killed;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } lq_entry_t;

    state_e           state_q, state_d;
    lq_entry_t        lq_q [LQ_DEPTH];
    lq_entry_t        lq_d [LQ_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [RW-1:0]    wrd_q, wrd_d;
    logic [DW-1:0]    wdata_q, wdata_d;

`ifdef REGFILE_WB_CLEAR_EN
    logic [RW-1:0]    clr_idx_q, clr_idx_d;
    logic             drop_q, drop_d;
`endif

    logic             ld_ready_c;
    logic             alu_wr_c;
    logic             ld_acc_c;
    logic             ld_keep_c;
    logic             pop_c;
    logic             push_c;
    lq_entry_t        push_entry_c;
    lq_entry_t        head_entry_c;

    // Load acceptance depends only on state and occupancy, never on ld_valid
    assign ld_ready_c = !rst && (state_q == ST_RUN) && (cnt_q < CNT_W'(LQ_DEPTH));

    // Qualify the incoming requests; x0 destinations never produce a write
    assign alu_wr_c     = wb.alu_valid && (wb.alu_rd != '0);
    assign ld_acc_c     = wb.ld_valid && ld_ready_c;
    assign ld_keep_c    = ld_acc_c && (wb.ld_rd != '0);
    assign head_entry_c = lq_q[head_q];

    // Next-state, arbitration and write-port selection
    always_comb begin
        state_d      = state_q;
        we_d         = 1'b0;
        wrd_d        = '0;
        wdata_d      = '0;
        pop_c        = 1'b0;
        push_c       = 1'b0;
        push_entry_c = '0;
`ifdef REGFILE_WB_CLEAR_EN
        clr_idx_d    = clr_idx_q;
        drop_d       = drop_q;
`endif

        case (state_q)
            ST_CLEAR: begin
`ifdef REGFILE_WB_CLEAR_EN
                // Zero one register per cycle; ALU results cannot be honoured here
                we_d  = 1'b1;
                wrd_d = clr_idx_q;
                if (wb.alu_valid) begin
                    drop_d = 1'b1;
                end
                if (clr_idx_q == '1) begin
                    state_d = ST_RUN;
                end else begin
                    clr_idx_d = clr_idx_q + RW'(1);
                end
`else
                state_d = ST_RUN;
`endif
            end

            ST_RUN: begin
                if (alu_wr_c) begin
                    // ALU wins the port; any colliding load goes to the queue
                    we_d    = 1'b1;
                    wrd_d   = wb.alu_rd;
                    wdata_d = wb.alu_data;
                    push_c  = ld_keep_c;
                    push_entry_c.killed = (wb.ld_rd == wb.alu_rd);
                end else if (cnt_q != '0) begin
                    // Drain the oldest queued load; killed entries just free the slot
                    pop_c  = 1'b1;
                    push_c = ld_keep_c;
                    if (!head_entry_c.killed) begin
                        we_d    = 1'b1;
                        wrd_d   = head_entry_c.rd;
                        wdata_d = head_entry_c.data;
                    end
                end else if (ld_keep_c) begin
                    // Empty queue and idle port: load bypasses straight through
                    we_d    = 1'b1;
                    wrd_d   = wb.ld_rd;
                    wdata_d = wb.ld_data;
                end
                push_entry_c.rd   = wb.ld_rd;
                push_entry_c.data = wb.ld_data;
            end

            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // Queue contents and pointers: squash older same-rd loads, then push/pop
    always_comb begin
        lq_d   = lq_q;
        head_d = head_q;
        tail_d = tail_q;

        if (alu_wr_c && (state_q == ST_RUN)) begin
            for (int i = 0; i < int'(LQ_DEPTH); i++) begin
                if (lq_q[i].rd == wb.alu_rd) begin
                    lq_d[i].killed = 1'b1;
                end
            end
        end

        if (pop_c) begin
            head_d = head_q + PTR_W'(1);
        end

        if (push_c) begin
            lq_d[tail_q] = push_entry_c;
            tail_d       = tail_q + PTR_W'(1);
        end

        cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // State, queue and registered write-port outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wrd_q   <= '0;
            wdata_q <= '0;
            for (int i = 0; i < int'(LQ_DEPTH); i++) begin
                lq_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wrd_q   <= wrd_d;
            wdata_q <= wdata_d;
            for (int i = 0; i < int'(LQ_DEPTH); i++) begin
                lq_q[i] <= lq_d[i];
            end
        end
    end

`ifdef REGFILE_WB_CLEAR_EN
    // Sweep index and sticky drop flag; the sweep always starts again at x1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_idx_q <= RW'(1);
            drop_q    <= 1'b0;
        end else begin
            clr_idx_q <= clr_idx_d;
            drop_q    <= drop_d;
        end
    end

    assign wb.stall    = (state_q == ST_CLEAR);
    assign wb.drop_err = drop_q;
`else
    assign wb.stall    = 1'b0;
    assign wb.drop_err = 1'b0;
`endif

    assign wb.ld_ready   = ld_ready_c;
    assign wb.lq_count   = cnt_q;
    assign wb.doRegWrite = we_q;
    assign wb.regToWrite = wrd_q;
    assign wb.write_data = wdata_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset values, optional clear sweep,
// ALU/load arbitration, queue ordering, squash and x0 handling.
module tb_regfile_writeback;

`ifdef REGFILE_WB_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    regfile_writeback_if bus ();

    regfile_writeback dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        rdy;   // ld_ready expected before the edge
        logic        we;    // expected write after the edge
        logic [4:0]  rd;
        logic [31:0] dat;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] adat,
                                logic lv, logic [4:0] lrd, logic [31:0] ldat,
                                logic rdy, logic we, logic [4:0] rd,
                                logic [31:0] dat, int cnt);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.rdy = rdy; v.we = we; v.rd = rd; v.dat = dat; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_data   = '0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        bus.alu_valid = v.av;
        bus.alu_rd    = v.ard;
        bus.alu_data  = v.adat;
        bus.ld_valid  = v.lv;
        bus.ld_rd     = v.lrd;
        bus.ld_data   = v.ldat;
        #1;
        chk($sformatf("v%0d ld_ready", idx), 32'(bus.ld_ready), 32'(v.rdy));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d doRegWrite", idx), 32'(bus.doRegWrite), 32'(v.we));
        if (v.we) begin
            chk($sformatf("v%0d regToWrite", idx), 32'(bus.regToWrite), 32'(v.rd));
            chk($sformatf("v%0d write_data", idx), bus.write_data, v.dat);
        end
        chk($sformatf("v%0d lq_count", idx), 32'(bus.lq_count), 32'(v.cnt));
        chk($sformatf("v%0d drop_err", idx), 32'(bus.drop_err), 32'd0);
        chk($sformatf("v%0d stall", idx), 32'(bus.stall), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " doRegWrite"}, 32'(bus.doRegWrite), 32'd0);
        chk({tag, " regToWrite"}, 32'(bus.regToWrite), 32'd0);
        chk({tag, " write_data"}, bus.write_data, 32'd0);
        chk({tag, " lq_count"}, 32'(bus.lq_count), 32'd0);
        chk({tag, " drop_err"}, 32'(bus.drop_err), 32'd0);
        chk({tag, " ld_ready"}, 32'(bus.ld_ready), 32'd0);
        chk({tag, " stall"}, 32'(bus.stall), 32'(CLR_EN));
    endtask

`ifdef REGFILE_WB_CLEAR_EN
    // Runs n sweep cycles, optionally firing an ALU result at cycle drop_at
    task automatic sweep(input int n, input int drop_at);
        for (int i = 1; i <= n; i++) begin
            bus.alu_valid = (i == drop_at);
            bus.alu_rd    = 5'd9;
            bus.alu_data  = 32'h1234;
            #1;
            chk($sformatf("sweep%0d ld_ready", i), 32'(bus.ld_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("sweep%0d doRegWrite", i), 32'(bus.doRegWrite), 32'd1);
            chk($sformatf("sweep%0d regToWrite", i), 32'(bus.regToWrite), 32'(i));
            chk($sformatf("sweep%0d write_data", i), bus.write_data, 32'd0);
            chk($sformatf("sweep%0d stall", i), 32'(bus.stall), 32'(i < 31));
            chk($sformatf("sweep%0d drop_err", i), 32'(bus.drop_err),
                32'(drop_at != 0 && i >= drop_at));
        end
        bus.alu_valid = 1'b0;
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();

        // Main vector table, applied in order from an empty queue in RUN
        //            av  ard    adat          lv  lrd     ldat         rdy we  rd     dat           cnt
        vecs.push_back(mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,       1, 1, 5'd5,  32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       1, 0, 5'd0,  32'h0,        0));
        vecs.push_back(mk(1, 5'd3,  32'h11,       1, 5'd4,  32'h22,      1, 1, 5'd3,  32'h11,       1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       1, 1, 5'd4,  32'h22,       0));
        vecs.push_back(mk(1, 5'd1,  32'h1,        1, 5'd10, 32'hA10,     1, 1, 5'd1,  32'h1,        1));
        vecs.push_back(mk(1, 5'd2,  32'h2,        1, 5'd11, 32'hA11,     1, 1, 5'd2,  32'h2,        2));
        vecs.push_back(mk(1, 5'd3,  32'h3,        1, 5'd12, 32'hA12,     0, 1, 5'd3,  32'h3,        2));
        vecs.push_back(mk(1, 5'd4,  32'h4,        1, 5'd12, 32'hA12,     0, 1, 5'd4,  32'h4,        2));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd12, 32'hA12,     0, 1, 5'd10, 32'hA10,      1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd12, 32'hA12,     1, 1, 5'd11, 32'hA11,      1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       1, 1, 5'd12, 32'hA12,      0));
        vecs.push_back(mk(1, 5'd6,  32'h66,       1, 5'd7,  32'hAA,      1, 1, 5'd6,  32'h66,       1));
        vecs.push_back(mk(1, 5'd7,  32'hBB,       0, 5'd0,  32'h0,       1, 1, 5'd7,  32'hBB,       1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       1, 0, 5'd0,  32'h0,        0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       1, 0, 5'd0,  32'h0,        0));
        vecs.push_back(mk(1, 5'd8,  32'h88,       1, 5'd9,  32'h99,      1, 1, 5'd8,  32'h88,       1));
        vecs.push_back(mk(1, 5'd0,  32'h5555,     1, 5'd0,  32'h77,      1, 1, 5'd9,  32'h99,       0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd0,  32'h33,      1, 0, 5'd0,  32'h0,        0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd13, 32'h1313,    1, 1, 5'd13, 32'h1313,     0));
        vecs.push_back(mk(1, 5'd14, 32'hE1,       1, 5'd14, 32'hE2,      1, 1, 5'd14, 32'hE1,       1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       1, 0, 5'd0,  32'h0,        0));

        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");

`ifdef REGFILE_WB_CLEAR_EN
        // Partial sweep with a dropped ALU result, then reset mid-sweep
        rst = 1'b0;
        sweep(10, 3);
        rst = 1'b1;
        #1;
        chk_reset_state("midsweep_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        sweep(31, 0);
`else
        rst = 1'b0;
        #1;
        chk("post_reset ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("post_reset stall", 32'(bus.stall), 32'd0);
`endif

        // An ALU result in RUN must not raise drop_err (checked per vector)
        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i], i);
        end

        // Fill the queue, then reset asynchronously mid-cycle
        apply_vec(mk(1, 5'd20, 32'h20, 1, 5'd21, 32'h21, 1, 1, 5'd20, 32'h20, 1), 100);
        apply_vec(mk(1, 5'd22, 32'h22, 1, 5'd23, 32'h23, 1, 1, 5'd22, 32'h22, 2), 101);
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("midqueue_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef REGFILE_WB_CLEAR_EN
        sweep(31, 0);
`endif
        apply_vec(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0, 5'd0, 32'h0, 0), 102);
        apply_vec(mk(0, 5'd0, 32'h0, 1, 5'd15, 32'hF0F0, 1, 1, 5'd15, 32'hF0F0, 0), 103);

        idle_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
